// File: rtl/fft_sched_pkg.sv
// Shared constants and state encoding for the FFT frame scheduler.
package fft_sched_pkg;

  localparam int N_POINTS     = 64;   // samples per frame, power of two
  localparam int FRAME_PERIOD = 185;  // minimum cycles between fft_start pulses
  localparam int CNT_W        = $clog2(N_POINTS);
  localparam int SPC_W        = $clog2(FRAME_PERIOD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/fft_align_dly.sv
// Fixed-depth shift register that lines the sample stream up with the
// pipeline controller's expectation relative to fft_start. Depth 0 is a wire.
module fft_align_dly #(
  parameter int W     = 32,
  parameter int DEPTH = 1
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign o_q = i_d;
    end else begin : g_shift
      logic [W-1:0] r_sr [DEPTH];

      // Shift one stage per cycle; clear wipes every stage so no stale sample survives a reset.
      always_ff @(posedge i_clk) begin
        if (i_clr) begin
          for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
        end else begin
          r_sr[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
      end

      assign o_q = r_sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/fft_frame_sched.sv
// Frame admission and output reframing in front of the 64-point FFT
// pipeline controller.
//
// Input handshake: a sample transfers on a rising edge where in_valid and
// in_ready are both high. in_ready depends only on registered state, never
// on in_valid. Once a frame is admitted the scheduler takes one slot per
// cycle for N_POINTS cycles; a slot with in_valid low is filled with 0+j0
// and flagged as an underrun so PE0 always sees a contiguous frame.
// Output side has no backpressure: out_ready is only monitored.
module fft_frame_sched
  import fft_sched_pkg::*;
#(
  parameter int DW        = 16,
  parameter int ALIGN_DLY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_re,
  input  logic [DW-1:0]    in_im,
  input  logic             in_last,
  output logic             fft_start,
  output logic [DW-1:0]    fft_din_re,
  output logic [DW-1:0]    fft_din_im,
  input  logic             fft_data_out_en,
  input  logic [DW-1:0]    fft_dout_re,
  input  logic [DW-1:0]    fft_dout_im,
  output logic             out_valid,
  output logic [DW-1:0]    out_re,
  output logic [DW-1:0]    out_im,
  output logic             out_last,
  output logic [CNT_W-1:0] out_idx,
  input  logic             out_ready,
  output logic             busy,
  output logic [15:0]      frame_cnt,
  output logic             err_underrun,
  output logic             err_last,
  output logic             err_overrun,
  input  logic             err_clr,
  output state_e           dbg_state
);

  localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'(N_POINTS - 1);
  localparam logic [SPC_W-1:0] SPC_LOAD = SPC_W'(FRAME_PERIOD - 1);

  state_e             r_state, w_next;
  logic [SPC_W-1:0]   r_spc;
  logic [CNT_W-1:0]   r_scnt;
  logic               r_start;
  logic [2*DW-1:0]    r_samp, w_din;
  logic [15:0]        r_frame_cnt;
  logic               r_out_valid;
  logic [DW-1:0]      r_out_re, r_out_im;
  logic [CNT_W-1:0]   r_out_idx;
  logic               r_err_u, r_err_l, r_err_o;
  logic               w_in_ready, w_accept, w_fill, w_last_smp;
  logic               w_set_u, w_set_l, w_set_o;

  // Next-state and in_ready. HOLD leaves one cycle before the spacing counter
  // hits zero so IDLE can admit on exactly the FRAME_PERIOD-th cycle.
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = (r_spc == '0);
        if (in_valid && w_in_ready) w_next = FILL;
      end
      FILL: begin
        w_in_ready = 1'b1;
        if (r_scnt == LAST_SMP) w_next = HOLD;
      end
      HOLD: begin
        if (r_spc <= SPC_W'(1)) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_accept   = (r_state == IDLE) && in_valid && w_in_ready;
  assign w_fill     = (r_state == FILL);
  assign w_last_smp = w_fill && (r_scnt == LAST_SMP);

  // Error set conditions: missing slot, in_last misplaced or absent, result dropped downstream.
  assign w_set_u = w_fill && !in_valid;
  assign w_set_l = (w_accept && in_last)
                || (w_fill && !w_last_smp && in_valid && in_last)
                || (w_last_smp && !(in_valid && in_last));
  assign w_set_o = r_out_valid && !out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Start pulse, spacing counter, sample counter and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start     <= 1'b0;
      r_spc       <= '0;
      r_scnt      <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_start <= w_accept;
      if (w_accept) begin
        r_spc       <= SPC_LOAD;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end else if (r_spc != '0) begin
        r_spc <= r_spc - SPC_W'(1);
      end
      if (w_accept)    r_scnt <= CNT_W'(1);
      else if (w_fill) r_scnt <= r_scnt + CNT_W'(1);
    end
  end

  // Sample capture: real data in the frame window, zero for underrun slots and outside frames.
  always_ff @(posedge clk) begin
    if (rst)                                 r_samp <= '0;
    else if (w_accept || (w_fill && in_valid)) r_samp <= {in_re, in_im};
    else                                     r_samp <= '0;
  end

  fft_align_dly #(
    .W     (2 * DW),
    .DEPTH (ALIGN_DLY)
  ) u_align_dly (
    .i_clk (clk),
    .i_clr (rst),
    .i_d   (r_samp),
    .o_q   (w_din)
  );

  // Result reframing: one register stage plus a per-frame index counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
      r_out_idx   <= '0;
    end else begin
      r_out_valid <= fft_data_out_en;
      r_out_re    <= fft_dout_re;
      r_out_im    <= fft_dout_im;
      if (r_out_valid) r_out_idx <= (r_out_idx == LAST_SMP) ? '0 : r_out_idx + CNT_W'(1);
    end
  end

  // Sticky errors; a new event wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_u <= 1'b0;
      r_err_l <= 1'b0;
      r_err_o <= 1'b0;
    end else begin
      r_err_u <= w_set_u ? 1'b1 : (err_clr ? 1'b0 : r_err_u);
      r_err_l <= w_set_l ? 1'b1 : (err_clr ? 1'b0 : r_err_l);
      r_err_o <= w_set_o ? 1'b1 : (err_clr ? 1'b0 : r_err_o);
    end
  end

  assign in_ready     = w_in_ready;
  assign fft_start    = r_start;
  assign fft_din_re   = w_din[2*DW-1:DW];
  assign fft_din_im   = w_din[DW-1:0];
  assign out_valid    = r_out_valid;
  assign out_re       = r_out_re;
  assign out_im       = r_out_im;
  assign out_idx      = r_out_idx;
  assign out_last     = r_out_valid && (r_out_idx == LAST_SMP);
  assign busy         = (r_state != IDLE) || (r_spc != '0);
  assign frame_cnt    = r_frame_cnt;
  assign err_underrun = r_err_u;
  assign err_last     = r_err_l;
  assign err_overrun  = r_err_o;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched: per-cycle output logs, expected-sample
// queue for the PE0 stream, hand-computed timing and flag expectations.
module tb_fft_frame_sched;
  import fft_sched_pkg::*;

  localparam int DW   = 16;
  localparam int A    = 1;
  localparam int LOGN = 8192;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          in_valid, in_ready, in_last;
  logic [DW-1:0] in_re, in_im;
  logic          fft_start;
  logic [DW-1:0] fft_din_re, fft_din_im;
  logic          fft_data_out_en;
  logic [DW-1:0] fft_dout_re, fft_dout_im;
  logic          out_valid, out_last, out_ready;
  logic [DW-1:0] out_re, out_im;
  logic [5:0]    out_idx;
  logic          busy;
  logic [15:0]   frame_cnt;
  logic          err_underrun, err_last, err_overrun, err_clr;
  state_e        dbg_state;

  fft_frame_sched #(.DW(DW), .ALIGN_DLY(A)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_re           (in_re),
    .in_im           (in_im),
    .in_last         (in_last),
    .fft_start       (fft_start),
    .fft_din_re      (fft_din_re),
    .fft_din_im      (fft_din_im),
    .fft_data_out_en (fft_data_out_en),
    .fft_dout_re     (fft_dout_re),
    .fft_dout_im     (fft_dout_im),
    .out_valid       (out_valid),
    .out_re          (out_re),
    .out_im          (out_im),
    .out_last        (out_last),
    .out_idx         (out_idx),
    .out_ready       (out_ready),
    .busy            (busy),
    .frame_cnt       (frame_cnt),
    .err_underrun    (err_underrun),
    .err_last        (err_last),
    .err_overrun     (err_overrun),
    .err_clr         (err_clr),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard / logs ----------------
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  logic [31:0] log_din   [LOGN];
  logic        log_start [LOGN];
  logic        log_ready [LOGN];
  logic        log_ov    [LOGN];
  logic        log_olast [LOGN];
  logic [5:0]  log_oidx  [LOGN];
  logic [31:0] log_od    [LOGN];
  int n_starts = 0;

  // Record outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      log_din[cyc]   <= {fft_din_re, fft_din_im};
      log_start[cyc] <= fft_start;
      log_ready[cyc] <= in_ready;
      log_ov[cyc]    <= out_valid;
      log_olast[cyc] <= out_last;
      log_oidx[cyc]  <= out_idx;
      log_od[cyc]    <= {out_re, out_im};
    end
    if (fft_start) n_starts = n_starts + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one 64-sample frame. Slots hole_lo..hole_hi are left invalid;
  // in_last is raised on samples last_a and last_b. t0 is the admission cycle.
  task automatic send_frame(input int base, input int hole_lo, input int hole_hi,
                            input int last_a, input int last_b, input bit hold_valid,
                            output int t0);
    int waited;
    bit hole;
    logic [15:0] re, im;
    waited   = 0;
    in_valid = hold_valid;
    in_re    = 16'(base);
    in_im    = 16'h1000;
    in_last  = 1'b0;
    while (!in_ready && waited < 400) begin
      tick();
      waited++;
    end
    if (!in_ready) chk("admit_timeout", 32'(in_ready), 32'd1);
    t0 = cyc;
    for (int k = 0; k < 64; k++) begin
      hole     = (k >= hole_lo) && (k <= hole_hi);
      re       = 16'(base + k);
      im       = 16'(32'h1000 + k);
      in_valid = !hole;
      in_re    = re;
      in_im    = im;
      in_last  = (k == last_a) || (k == last_b);
      exp_q.push_back(hole ? 32'h0 : {re, im});
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Compare one admitted frame against the expected queue and its timing.
  task automatic check_frame(input int t0);
    while (cyc < t0 + A + 103) tick();
    chk("start_pulse", 32'(log_start[t0+1]), 32'd1);
    chk("no_early_start", 32'(log_start[t0]), 32'd0);
    chk("din_before", log_din[t0+A], 32'h0);
    for (int k = 0; k < 64; k++) chk("din", log_din[t0+1+A+k], exp_q.pop_front());
    chk("din_after", log_din[t0+A+65], 32'h0);
    chk("ready_in_hold", 32'(log_ready[t0+100]), 32'd0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_start"}, 32'(fft_start), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    chk({tag, "_errs"}, {29'd0, err_underrun, err_last, err_overrun}, 32'd0);
    chk({tag, "_din"}, {fft_din_re, fft_din_im}, 32'h0);
    chk({tag, "_out"}, {24'd0, out_valid, out_last, out_idx}, 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- main sequence ----------------
  int t0, to, n_snap, waited;
  int ta[4];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; in_last = 1'b0;
    fft_data_out_en = 1'b0; fft_dout_re = '0; fft_dout_im = '0;
    out_ready = 1'b1; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_state("reset");

    // Single gapless frame 1..64.
    send_frame(1, 99, -1, 63, -1, 1'b0, t0);
    check_frame(t0);
    chk("single_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("single_errs", {29'd0, err_underrun, err_last, err_overrun}, 32'd0);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_state", 32'(dbg_state), 32'(HOLD));

    // Back-to-back: upstream valid continuously for 256 samples.
    for (int i = 0; i < 4; i++) send_frame(32'h100 * (i + 1), 99, -1, 63, -1, 1'b1, ta[i]);
    for (int i = 0; i < 4; i++) check_frame(ta[i]);
    chk("spacing_first", 32'(ta[0] - t0), 32'd185);
    for (int i = 1; i < 4; i++) chk("spacing", 32'(ta[i] - ta[i-1]), 32'd185);
    chk("b2b_frame_cnt", 32'(frame_cnt), 32'd5);

    // Underrun on slots 10..12, then a clean frame.
    send_frame(32'h3000, 10, 12, 63, -1, 1'b0, t0);
    check_frame(t0);
    chk("underrun_set", 32'(err_underrun), 32'd1);
    chk("underrun_no_last_err", 32'(err_last), 32'd0);
    pulse_clr();
    chk("underrun_clr", 32'(err_underrun), 32'd0);
    send_frame(32'h4000, 99, -1, 63, -1, 1'b0, t0);
    check_frame(t0);
    chk("after_underrun_clean", 32'(err_underrun), 32'd0);

    // in_last early on sample 30 (also present on 63).
    send_frame(32'h5000, 99, -1, 30, 63, 1'b0, t0);
    check_frame(t0);
    chk("last_early", 32'(err_last), 32'd1);
    chk("last_early_cnt", 32'(frame_cnt), 32'd8);
    pulse_clr();
    chk("last_clr", 32'(err_last), 32'd0);

    // in_last missing on sample 63.
    send_frame(32'h6000, 99, -1, -1, -1, 1'b0, t0);
    check_frame(t0);
    chk("last_missing", 32'(err_last), 32'd1);
    chk("last_missing_cnt", 32'(frame_cnt), 32'd9);

    // Output reframing: idle out_ready low is harmless, then a 64-beat burst.
    out_ready = 1'b0;
    repeat (3) tick();
    chk("overrun_idle", 32'(err_overrun), 32'd0);
    out_ready = 1'b1;
    to = cyc;
    for (int k = 0; k < 64; k++) begin
      if (k == 30) chk("overrun_before", 32'(err_overrun), 32'd0);
      fft_data_out_en = 1'b1;
      fft_dout_re     = 16'(32'h4000 + k);
      fft_dout_im     = 16'(32'h5000 + k);
      out_ready       = (k != 41);
      tick();
    end
    fft_data_out_en = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("out_valid_pre", 32'(log_ov[to]), 32'd0);
    for (int k = 0; k < 64; k++) begin
      chk("out_valid", 32'(log_ov[to+1+k]), 32'd1);
      chk("out_idx", 32'(log_oidx[to+1+k]), 32'(k));
      chk("out_last", 32'(log_olast[to+1+k]), 32'(k == 63));
      chk("out_data", log_od[to+1+k], {16'(32'h4000 + k), 16'(32'h5000 + k)});
    end
    chk("out_valid_post", 32'(log_ov[to+65]), 32'd0);
    chk("out_idx_wrap", 32'(out_idx), 32'd0);
    chk("overrun_set", 32'(err_overrun), 32'd1);

    // Reset at sample 20 of a frame.
    waited = 0;
    while (!in_ready && waited < 400) begin
      tick();
      waited++;
    end
    if (!in_ready) chk("rst_admit_timeout", 32'(in_ready), 32'd1);
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_re    = 16'(32'h7000 + k);
      in_im    = 16'(32'h7100 + k);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk_reset_state("midrst");
    n_snap = n_starts;
    repeat (10) tick();
    chk("midrst_no_start", 32'(n_starts), 32'(n_snap));
    send_frame(32'h8000, 99, -1, 63, -1, 1'b0, t0);
    check_frame(t0);
    chk("fresh_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("fresh_errs", {29'd0, err_underrun, err_last, err_overrun}, 32'd0);

    // Ten admitted frames plus the one dropped by reset.
    chk("start_total", 32'(n_starts), 32'd11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
